// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the
// instruction-fetch port (read-only) and the load/store data port.
// One request is served at a time: ACCESS drives the RAM for one cycle, WAIT
// covers the remaining read latency, and RESP returns a one-cycle response.
//
// Handshake: a request (x_req with its operands) is sampled only at the clock
// edge that ends IDLE or RESP. A sampled request is committed; the requester
// holds x_req and its operands stable until it sees the one-cycle x_gnt, and
// may then drop or change them. x_rvalid is a one-cycle pulse MEM_LAT cycles
// after x_gnt; x_rdata is 0 whenever x_rvalid is 0 and on write acknowledges.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate the winner on
// conflicts; otherwise data always beats fetch.
// MEM_LAT legal range is 1..8.

module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic              win_data_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [15:0]       conflict_q;

  logic arb_en;
  logic conflict;
  logic pick_data;

  // An arbitration edge is the end of IDLE or RESP with any request present.
  assign arb_en   = ((state_q == IDLE) || (state_q == RESP)) && (if_req || d_req);
  assign conflict = if_req && d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Last conflict winner: 0 = fetch, 1 = data. Only conflicts move it, so the
  // first conflict after reset goes to data.
  logic last_data_q;

  assign pick_data = conflict ? !last_data_q : d_req;

  // Remember who won the most recent conflict.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      last_data_q <= 1'b0;
    end else if (arb_en && conflict) begin
      last_data_q <= pick_data;
    end
  end
`else
  // Fixed priority: data wins whenever it is requesting.
  assign pick_data = d_req;
`endif

  // State and wait-counter registers.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Latch the winner's operands at the arbitration edge; the loser is dropped.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      win_data_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (arb_en) begin
      win_data_q <= pick_data;
      we_q       <= pick_data && d_we;
      addr_q     <= pick_data ? d_addr : if_addr;
      wdata_q    <= pick_data ? d_wdata : '0;
    end
  end

  // Saturating count of arbitrations where both ports were requesting.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      conflict_q <= 16'd0;
    end else if (arb_en && conflict && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  // Next-state logic; WAIT lasts MEM_LAT-1 cycles via the down-counter.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (arb_en) state_d = ACCESS;
      end
      ACCESS: begin
        if (MEM_LAT > 1) begin
          state_d = WAIT;
          wait_d  = 4'(MEM_LAT - 1);
        end else begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (wait_q <= 4'd1) begin
          state_d = RESP;
          wait_d  = 4'd0;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RESP: begin
        state_d = arb_en ? ACCESS : IDLE;
      end
      default: begin
        state_d = IDLE;
        wait_d  = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the state only, so they drop with async reset.
  always_comb begin
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (win_data_q) d_gnt  = 1'b1;
        else            if_gnt = 1'b1;
      end
      RESP: begin
        if (win_data_q) begin
          d_rvalid = 1'b1;
          d_rdata  = we_q ? '0 : mem_rdata;
        end else begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
      end
      default: begin
      end
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run
// checked cycle by cycle against a transaction-level reference model.
// Build with MEM_ARB_ROUND_ROBIN_EN defined to check the alternating policy.

module tb_mem_port_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int MEM_LAT = 3;
  localparam int OW      = 87;

  logic              clk100;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic [15:0]       conflict_cnt;

  // RAM behind the arbiter, with a backdoor write port for preloading.
  logic [DATA_W-1:0] ram     [0:65535];
  logic [DATA_W-1:0] ref_mem [0:65535];
  logic [DATA_W-1:0] rd_pipe [0:MEM_LAT-1];
  logic              bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [DATA_W-1:0] bd_data;

  int checks;
  int errors;
  logic [DATA_W-1:0] exp_q[$];

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk100      (clk100),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .conflict_cnt(conflict_cnt)
  );

  // Clock / reset block
  initial begin
    clk100 = 1'b0;
    forever #5 clk100 = ~clk100;
  end

  // Synchronous RAM: read data appears MEM_LAT cycles after mem_en is sampled.
  always @(posedge clk100) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : '0;
    for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  function automatic logic [OW-1:0] obs();
    return {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
            mem_en, mem_we, mem_addr, mem_wdata, busy, conflict_cnt};
  endfunction

  function automatic logic [ADDR_W-1:0] pick_addr();
    logic [ADDR_W-1:0] v;
    v = ADDR_W'($urandom_range(0, 15));
    return ($urandom_range(0, 1) == 1) ? v : (16'hFFF0 | v);
  endfunction

  // Driver tasks
  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk100);
    rst = 1'b0;
    @(negedge clk100);
  endtask

  task automatic preload();
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk100);
      if (i < 16)       a = ADDR_W'(i);
      else if (i < 32)  a = 16'hFFE0 + ADDR_W'(i);
      else              a = 16'h0010;
      bd_we   = 1'b1;
      bd_addr = a;
      bd_data = (i == 32) ? 16'hBEEF : DATA_W'($urandom);
      ref_mem[a] = bd_data;
    end
    @(negedge clk100);
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [OW-1:0] got;
    got = obs();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_held: outputs=%h required 0", got);
    end
    rst = 1'b0;
    @(negedge clk100);
    got = obs();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_idle: outputs=%h required 0", got);
    end
  endtask

  task automatic test_fetch_read();
    @(negedge clk100);
    if_req  = 1'b1;
    if_addr = 16'h0010;
    @(negedge clk100);
    checks++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin
      errors++;
      $display("FAIL fetch_access: if_gnt=%b d_gnt=%b mem_en=%b mem_we=%b mem_addr=%h required 1 0 1 0 0010",
               if_gnt, d_gnt, mem_en, mem_we, mem_addr);
    end
    if_req = 1'b0;
    for (int k = 2; k <= MEM_LAT; k++) begin
      @(negedge clk100);
      checks++;
      if (if_rvalid !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL fetch_wait: if_rvalid=%b mem_en=%b busy=%b required 0 0 1", if_rvalid, mem_en, busy);
      end
    end
    @(negedge clk100);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 16'hBEEF || d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_resp: if_rvalid=%b if_rdata=%h d_rvalid=%b required 1 beef 0", if_rvalid, if_rdata, d_rvalid);
    end
    @(negedge clk100);
    checks++;
    if (busy !== 1'b0 || if_rvalid !== 1'b0 || if_rdata !== '0) begin
      errors++;
      $display("FAIL fetch_idle: busy=%b if_rvalid=%b if_rdata=%h required 0 0 0", busy, if_rvalid, if_rdata);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk100);
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 16'h0020;
    d_wdata = 16'h1234;
    @(negedge clk100);
    checks++;
    if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 16'h1234) begin
      errors++;
      $display("FAIL write_access: d_gnt=%b mem_en=%b mem_we=%b addr=%h wdata=%h required 1 1 1 0020 1234",
               d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    ref_mem[16'h0020] = 16'h1234;
    d_req = 1'b0;
    d_we  = 1'b0;
    for (int k = 2; k <= MEM_LAT; k++) begin
      @(negedge clk100);
      checks++;
      if (mem_we !== 1'b0 || d_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL write_wait: mem_we=%b d_rvalid=%b required 0 0", mem_we, d_rvalid);
      end
    end
    @(negedge clk100);
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== '0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL write_ack: d_rvalid=%b d_rdata=%h mem_we=%b required 1 0000 0", d_rvalid, d_rdata, mem_we);
    end
    // Read request issued in the same cycle as the write acknowledge.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 16'h0020;
    @(negedge clk100);
    checks++;
    if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0020) begin
      errors++;
      $display("FAIL read_access: d_gnt=%b mem_en=%b mem_we=%b addr=%h required 1 1 0 0020", d_gnt, mem_en, mem_we, mem_addr);
    end
    d_req = 1'b0;
    repeat (MEM_LAT) @(negedge clk100);
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 16'h1234) begin
      errors++;
      $display("FAIL read_back: d_rvalid=%b d_rdata=%h required 1 1234", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_conflict();
    logic [3:0] order;
    int n;
    int guard;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    order = 4'b0101;
`else
    order = 4'b1111;
`endif
    do_reset();
    if_req  = 1'b1;
    if_addr = 16'h0003;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 16'h0004;
    n = 0;
    guard = 0;
    while (n < 4 && guard < 8 * (MEM_LAT + 1)) begin
      @(negedge clk100);
      guard++;
      if (if_gnt === 1'b1 || d_gnt === 1'b1) begin
        checks++;
        if (d_gnt !== order[n] || if_gnt !== !order[n]) begin
          errors++;
          $display("FAIL conflict_order%0d: d_gnt=%b if_gnt=%b required %b %b", n, d_gnt, if_gnt, order[n], !order[n]);
        end
        n++;
        if (n == 4) idle_inputs();
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      idle_inputs();
      $display("FAIL conflict_grants: saw %0d grants required 4", n);
    end
    repeat (MEM_LAT + 1) @(negedge clk100);
    checks++;
    if (conflict_cnt !== 16'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL conflict_count: conflict_cnt=%0d busy=%b required 4 0", conflict_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk100);
    if_req  = 1'b1;
    if_addr = 16'h0005;
    @(negedge clk100);
    if_req = 1'b0;
    @(negedge clk100);
    @(negedge clk100);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy: busy=%b required 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: outputs=%h required 0", obs());
    end
    @(negedge clk100);
    rst = 1'b0;
    seen = 0;
    repeat (MEM_LAT + 3) begin
      @(negedge clk100);
      if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: %0d active cycles required 0", seen);
    end
    if_req  = 1'b1;
    if_addr = 16'h0005;
    @(negedge clk100);
    checks++;
    if (if_gnt !== 1'b1 || mem_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_regnt: if_gnt=%b mem_en=%b required 1 1", if_gnt, mem_en);
    end
    if_req = 1'b0;
    repeat (MEM_LAT) @(negedge clk100);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== ref_mem[16'h0005]) begin
      errors++;
      $display("FAIL reset_mid_resp: if_rvalid=%b if_rdata=%h required 1 %h", if_rvalid, if_rdata, ref_mem[16'h0005]);
    end
  endtask

  task automatic test_random();
    int acc_c, resp_c, ready_c, exp_cnt;
    logic win_data, win_we, conf, f_pend, d_pend;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata, rd;
    logic [OW-1:0] exp_v, got;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_data;
    last_data = 1'b0;
`endif
    do_reset();
    exp_q.delete();
    acc_c = -1; resp_c = -1; ready_c = 0; exp_cnt = 0;
    win_data = 1'b0; win_we = 1'b0; win_addr = '0; win_wdata = '0;
    f_pend = 1'b0; d_pend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      // Expected outputs for cycle c from the transaction timeline.
      rd = '0;
      if (c == resp_c && exp_q.size() > 0) rd = exp_q.pop_front();
      exp_v = {(c == acc_c) && !win_data,
               (c == resp_c) && !win_data,
               ((c == resp_c) && !win_data) ? rd : 16'h0,
               (c == acc_c) && win_data,
               (c == resp_c) && win_data,
               ((c == resp_c) && win_data) ? rd : 16'h0,
               (c == acc_c),
               (c == acc_c) && win_we,
               (c == acc_c) ? win_addr : 16'h0,
               (c == acc_c) ? win_wdata : 16'h0,
               (acc_c >= 0) && (c >= acc_c) && (c <= resp_c),
               16'(exp_cnt)};
      got = obs();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h required %h", c, got, exp_v);
      end
      // Requesters: hold until granted, then maybe issue a new request.
      if (f_pend && if_gnt === 1'b1) f_pend = 1'b0;
      if (d_pend && d_gnt === 1'b1) d_pend = 1'b0;
      if (c < 590) begin
        if (!f_pend && $urandom_range(0, 2) == 0) begin
          f_pend  = 1'b1;
          if_addr = pick_addr();
        end
        if (!d_pend && $urandom_range(0, 2) == 0) begin
          d_pend  = 1'b1;
          d_we    = ($urandom_range(0, 1) == 1);
          d_addr  = pick_addr();
          d_wdata = DATA_W'($urandom);
        end
      end
      if_req = f_pend;
      d_req  = d_pend;
      // Reference model: one outstanding access, served in MEM_LAT+1 cycles.
      if (c >= ready_c && (if_req || d_req)) begin
        conf = if_req && d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win_data = conf ? !last_data : d_req;
        if (conf) last_data = win_data;
`else
        win_data = d_req;
`endif
        win_we    = win_data && d_we;
        win_addr  = win_data ? d_addr : if_addr;
        win_wdata = win_data ? d_wdata : '0;
        if (win_we) begin
          exp_q.push_back('0);
          ref_mem[win_addr] = win_wdata;
        end else begin
          exp_q.push_back(ref_mem[win_addr]);
        end
        if (conf && exp_cnt < 65535) exp_cnt++;
        acc_c   = c + 1;
        resp_c  = c + 1 + MEM_LAT;
        ready_c = resp_c;
      end
      @(negedge clk100);
    end
    idle_inputs();
    repeat (MEM_LAT + 2) @(negedge clk100);
  endtask

  task automatic test_saturation();
    logic [15:0] exp_seq [0:3];
    int n;
    int guard;
    exp_seq[0] = 16'hFFFE;
    exp_seq[1] = 16'hFFFF;
    exp_seq[2] = 16'hFFFF;
    exp_seq[3] = 16'hFFFF;
    do_reset();
    dut.conflict_q = 16'hFFFD;
    if_req = 1'b1;
    d_req  = 1'b1;
    n = 0;
    guard = 0;
    while (n < 4 && guard < 8 * (MEM_LAT + 1)) begin
      @(negedge clk100);
      guard++;
      if (if_gnt === 1'b1 || d_gnt === 1'b1) begin
        checks++;
        if (conflict_cnt !== exp_seq[n]) begin
          errors++;
          $display("FAIL saturation%0d: conflict_cnt=%h required %h", n, conflict_cnt, exp_seq[n]);
        end
        n++;
        if (n == 4) idle_inputs();
      end
    end
    idle_inputs();
    repeat (MEM_LAT + 2) @(negedge clk100);
    checks++;
    if (n != 4 || conflict_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturation_final: grants=%0d conflict_cnt=%h required 4 ffff", n, conflict_cnt);
    end
  endtask

  // Main sequence and final report
  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bd_we   = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    idle_inputs();
    preload();
    test_reset();
    test_fetch_read();
    test_write_read();
    test_conflict();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
